// File: rtl/seq_shifter.sv
// seq_shifter: iterative ARM-style barrel shift (LSL/LSR/ASR/ROR) with the
// C-flag result. Ports: clk, reset, start/ready, data_in, sh, amount,
// carry_in -> done pulse, result, carry_out. Macro SEQ_SHIFTER_FAST_EN
// enables 4-bit steps while at least 4 positions remain.
module seq_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [1:0]  sh,
  input  logic [7:0]  amount,
  input  logic        carry_in,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  sh_q, sh_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  // One-position step; returns {carry, data}.
  function automatic logic [32:0] step1(
    input logic [31:0] d,
    input logic [1:0]  s
  );
    logic [32:0] r;
    unique case (s)
      SH_LSL:  r = {d[31], d[30:0], 1'b0};
      SH_LSR:  r = {d[0], 1'b0, d[31:1]};
      SH_ASR:  r = {d[0], d[31], d[31:1]};
      default: r = {d[0], d[0], d[31:1]};
    endcase
    return r;
  endfunction

`ifdef SEQ_SHIFTER_FAST_EN
  // Four-position step; carry is the last bit shifted out.
  function automatic logic [32:0] step4(
    input logic [31:0] d,
    input logic [1:0]  s
  );
    logic [32:0] r;
    unique case (s)
      SH_LSL:  r = {d[28], d[27:0], 4'b0};
      SH_LSR:  r = {d[3], 4'b0, d[31:4]};
      SH_ASR:  r = {d[3], {4{d[31]}}, d[31:4]};
      default: r = {d[3], d[3:0], d[31:4]};
    endcase
    return r;
  endfunction
`endif

  logic [32:0] stp;
  logic [7:0]  stp_n;

  always_comb begin
`ifdef SEQ_SHIFTER_FAST_EN
    if (cnt_q >= 8'd4) begin
      stp   = step4(data_q, sh_q);
      stp_n = 8'd4;
    end else begin
      stp   = step1(data_q, sh_q);
      stp_n = 8'd1;
    end
`else
    stp   = step1(data_q, sh_q);
    stp_n = 8'd1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d = data_in;
          sh_d   = sh;
          cnt_d  = amount;
          if (amount == 8'd0) begin
            state_d  = DONE;
            result_d = data_in;
            cout_d   = carry_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = stp[31:0];
        cnt_d  = cnt_q - stp_n;
        if (cnt_q == stp_n) begin
          state_d  = DONE;
          result_d = stp[31:0];
          cout_d   = stp[32];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors for seq_shifter with a queue-based
// scoreboard; a monitor checks every done pulse against the queue.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [1:0]  sh;
  logic [7:0]  amount;
  logic        carry_in;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  seq_shifter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .sh        (sh),
    .amount    (amount),
    .carry_in  (carry_in),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  function automatic int lat_of(input int n);
`ifdef SEQ_SHIFTER_FAST_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Monitor: compare every done pulse against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (!reset && done) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_carry"}, {31'b0, carry_out}, {31'b0, e.c});
        chk({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
        chk({e.name, "_ready_low"}, {31'b0, ready}, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {31'b0, ready}, 32'd1);
  endtask

  // Issue one operation; expectation is queued before the accept edge.
  task automatic issue(input string nm, input logic [1:0] s,
                       input logic [31:0] d, input int n,
                       input logic ci, input logic [31:0] er,
                       input logic ec);
    exp_t e;
    @(negedge clk);
    wait_ready();
    e.res  = er;
    e.c    = ec;
    e.lat  = lat_of(n);
    e.acc  = cyc + 1;
    e.name = nm;
    exp_q.push_back(e);
    start    = 1'b1;
    sh       = s;
    data_in  = d;
    amount   = 8'(n);
    carry_in = ci;
    @(negedge clk);
    start    = 1'b0;
    data_in  = 32'hDEAD_BEEF;
    amount   = 8'd7;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    sh       = '0;
    amount   = '0;
    carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    reset = 1'b0;

    issue("lsl1", 2'b00, 32'h8000_0001, 1, 1'b0, 32'h0000_0002, 1'b1);
    drain();
    issue("asr40", 2'b10, 32'h8000_0000, 40, 1'b0, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue("ror1", 2'b11, 32'h0000_0001, 1, 1'b0, 32'h8000_0000, 1'b1);
    issue("ror32", 2'b11, 32'h8000_0001, 32, 1'b0, 32'h8000_0001, 1'b1);
    issue("lsr0", 2'b01, 32'h1234_5678, 0, 1'b1, 32'h1234_5678, 1'b1);
    issue("lsr33", 2'b01, 32'hFFFF_FFFF, 33, 1'b1, 32'h0, 1'b0);
    issue("lsl4", 2'b00, 32'h1234_5678, 4, 1'b0, 32'h2345_6780, 1'b1);
    issue("lsl32", 2'b00, 32'h0000_000F, 32, 1'b0, 32'h0, 1'b1);
    issue("lsr32", 2'b01, 32'h8000_0000, 32, 1'b0, 32'h0, 1'b1);
    issue("asr32p", 2'b10, 32'h7FFF_FFFF, 32, 1'b1, 32'h0, 1'b0);
    issue("ror8", 2'b11, 32'h1234_5678, 8, 1'b1, 32'h7812_3456, 1'b0);
    issue("lsr5", 2'b01, 32'h8000_0010, 5, 1'b0, 32'h0400_0000, 1'b1);
    issue("asr255", 2'b10, 32'h8000_0000, 255, 1'b0, 32'hFFFF_FFFF, 1'b1);
    issue("lsl0", 2'b00, 32'hCAFE_0001, 0, 1'b0, 32'hCAFE_0001, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    chk("hold_result", result, 32'hCAFE_0001);
    chk("hold_carry", {31'b0, carry_out}, 32'd0);

    // Starts in SHIFT and DONE must be ignored.
    issue("lsl10", 2'b00, 32'h0000_0001, 10, 1'b0, 32'h0000_0400, 1'b0);
    base = 1;
    for (int k = 2; k <= lat_of(10); k++) begin
      start    = (k == 3 || k == lat_of(10));
      data_in  = 32'hFFFF_FFFF;
      sh       = 2'b11;
      amount   = 8'd1;
      carry_in = 1'b1;
      @(negedge clk);
      base = k;
    end
    start = 1'b0;
    chk("ign_steps", base, lat_of(10));
    drain();
    repeat (4) @(negedge clk);
    chk("ign_no_extra", exp_q.size(), 0);

    // Reset in cycle 5 of a 20-step shift.
    issue("lsl20", 2'b00, 32'h0000_0001, 20, 1'b1, 32'h0010_0000, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    done_seen = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", {31'b0, ready}, 32'd1);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_carry", {31'b0, carry_out}, 32'd0);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", done_seen, 0);

    issue("post_rst", 2'b11, 32'h0000_0001, 1, 1'b0, 32'h8000_0000, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
